// File: rtl/bullet_controller_pkg.sv
// Shared types and constants for the per-player bullet controller.
// Coordinates are tile units on the 20x15 map; all arithmetic is signed int.
package bullet_controller_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CHECK  = 2'd1,
      S_FLIGHT = 2'd2
   } bul_state_t;

   localparam int GRID_W        = 20;
   localparam int GRID_H        = 15;
   localparam int TILE_EMPTY    = 0;
   localparam int TILE_STEEL    = 1;
   localparam int TILE_BRICK    = 2;
   localparam int TILE_PICKUP_A = 3;
   localparam int TILE_PICKUP_B = 4;
   localparam int BUL_NONE      = -1;

   function automatic int step_x(dir_t d);
      case (d)
         DIR_RIGHT: return 1;
         DIR_LEFT:  return -1;
         default:   return 0;
      endcase
   endfunction

   function automatic int step_y(dir_t d);
      case (d)
         DIR_UP:   return -1;
         DIR_DOWN: return 1;
         default:  return 0;
      endcase
   endfunction

   function automatic logic in_bounds(int x, int y);
      return (x >= 0) && (x < GRID_W) && (y >= 0) && (y < GRID_H);
   endfunction

endpackage

// File: rtl/bullet_controller_if.sv
// Game-side signal bundle of one bullet controller: tank/enemy positions,
// map lookup, bullet position and hit reports.
interface bullet_controller_if;
   logic       frame_clk;
   logic       fire;
   int         TankX;
   int         TankY;
   logic [1:0] TankDir;
   int         EnemyX;
   int         EnemyY;
   int         tile_idx;
   int         tile_val;
   int         BulX;
   int         BulY;
   logic       active;
   logic       wall_hit;
   int         wall_idx;
   logic       tank_hit;

   // master: game logic / map owner side
   modport master (
      output frame_clk, fire, TankX, TankY, TankDir, EnemyX, EnemyY, tile_val,
      input  tile_idx, BulX, BulY, active, wall_hit, wall_idx, tank_hit
   );

   modport slave (
      input  frame_clk, fire, TankX, TankY, TankDir, EnemyX, EnemyY, tile_val,
      output tile_idx, BulX, BulY, active, wall_hit, wall_idx, tank_hit
   );
endinterface

// File: rtl/bullet_controller_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge
// detector; pulse is high for one Clk cycle, two cycles after the input rises.
module sync_edge (
   input  logic Clk,
   input  logic Reset_n,
   input  logic async_in,
   output logic pulse
);

   logic [2:0] sr;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         sr <= '0;
      end else begin
         sr <= {sr[1:0], async_in};
      end
   end

   assign pulse = sr[1] & ~sr[2];

endmodule

// File: rtl/bullet_controller.sv
// One player's bullet: launch on fire, step one tile every MOVE_DIV frames,
// resolve bounds / tank / steel / brick collisions on each step.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | no bullet; cooldown counts down on frame ticks; fire launches
//   S_CHECK  | one cycle: candidate tile looked up, collision resolved
//   S_FLIGHT | bullet on map; frame ticks counted until next step
module bullet_controller
   import bullet_controller_pkg::*;
#(
   parameter int MOVE_DIV = 4,
   parameter int COOLDOWN = 8
) (
   input  logic               Clk,
   input  logic               Reset_n,
   bullet_controller_if.slave bus
);

   bul_state_t state, state_d;
   dir_t       dir, dir_d;
   int         bul_x, bul_x_d, bul_y, bul_y_d;
   int         nxt_x, nxt_x_d, nxt_y, nxt_y_d;
   int         frame_cnt, frame_cnt_d;
   int         cool_cnt, cool_cnt_d;
   int         wall_idx_r, wall_idx_d;
   logic       active_r, active_d;
   logic       wall_hit_r, wall_hit_d;
   logic       tank_hit_r, tank_hit_d;

   logic       tick, fire_req;
   logic       nxt_ok, kill;
   int         chk_idx;

   sync_edge u_sync_frame (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .async_in (bus.frame_clk),
      .pulse    (tick)
   );

   sync_edge u_sync_fire (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .async_in (bus.fire),
      .pulse    (fire_req)
   );

   assign nxt_ok  = in_bounds(nxt_x, nxt_y);
   assign chk_idx = nxt_y * GRID_W + nxt_x;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state      <= S_IDLE;
         dir        <= DIR_UP;
         bul_x      <= BUL_NONE;
         bul_y      <= BUL_NONE;
         nxt_x      <= 0;
         nxt_y      <= 0;
         frame_cnt  <= 0;
         cool_cnt   <= 0;
         wall_idx_r <= 0;
         active_r   <= 1'b0;
         wall_hit_r <= 1'b0;
         tank_hit_r <= 1'b0;
      end else begin
         state      <= state_d;
         dir        <= dir_d;
         bul_x      <= bul_x_d;
         bul_y      <= bul_y_d;
         nxt_x      <= nxt_x_d;
         nxt_y      <= nxt_y_d;
         frame_cnt  <= frame_cnt_d;
         cool_cnt   <= cool_cnt_d;
         wall_idx_r <= wall_idx_d;
         active_r   <= active_d;
         wall_hit_r <= wall_hit_d;
         tank_hit_r <= tank_hit_d;
      end
   end

   always_comb begin
      state_d     = state;
      dir_d       = dir;
      bul_x_d     = bul_x;
      bul_y_d     = bul_y;
      nxt_x_d     = nxt_x;
      nxt_y_d     = nxt_y;
      frame_cnt_d = frame_cnt;
      cool_cnt_d  = cool_cnt;
      wall_idx_d  = wall_idx_r;
      active_d    = active_r;
      wall_hit_d  = 1'b0;
      tank_hit_d  = 1'b0;
      kill        = 1'b0;

      case (state)
         S_IDLE: begin
            if (tick && cool_cnt != 0) begin
               cool_cnt_d = cool_cnt - 1;
            end
            if (fire_req && cool_cnt == 0) begin
               dir_d   = dir_t'(bus.TankDir);
               nxt_x_d = bus.TankX + step_x(dir_t'(bus.TankDir));
               nxt_y_d = bus.TankY + step_y(dir_t'(bus.TankDir));
               state_d = S_CHECK;
            end
         end

         S_FLIGHT: begin
            // frame_cnt can already equal MOVE_DIV when a tick landed in CHECK
            if ((tick && frame_cnt >= MOVE_DIV - 1) || frame_cnt >= MOVE_DIV) begin
               frame_cnt_d = 0;
               nxt_x_d     = bul_x + step_x(dir);
               nxt_y_d     = bul_y + step_y(dir);
               state_d     = S_CHECK;
            end else if (tick) begin
               frame_cnt_d = frame_cnt + 1;
            end
         end

         S_CHECK: begin
            if (!nxt_ok) begin
               kill = 1'b1;
            end else if (nxt_x == bus.EnemyX && nxt_y == bus.EnemyY) begin
               tank_hit_d = 1'b1;
               kill       = 1'b1;
            end else if (bus.tile_val == TILE_STEEL) begin
               kill = 1'b1;
            end else if (bus.tile_val == TILE_BRICK) begin
               wall_hit_d = 1'b1;
               wall_idx_d = chk_idx;
               kill       = 1'b1;
            end else begin
               bul_x_d  = nxt_x;
               bul_y_d  = nxt_y;
               active_d = 1'b1;
               state_d  = S_FLIGHT;
               if (tick) begin
                  frame_cnt_d = frame_cnt + 1;
               end
            end

            if (kill) begin
               bul_x_d     = BUL_NONE;
               bul_y_d     = BUL_NONE;
               active_d    = 1'b0;
               cool_cnt_d  = COOLDOWN;
               frame_cnt_d = 0;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.tile_idx = (state == S_CHECK && nxt_ok) ? chk_idx : 0;
   assign bus.BulX     = bul_x;
   assign bus.BulY     = bul_y;
   assign bus.active   = active_r;
   assign bus.wall_hit = wall_hit_r;
   assign bus.wall_idx = wall_idx_r;
   assign bus.tank_hit = tank_hit_r;

endmodule

// File: tb/tb_bullet_controller.sv
// Self-checking bench for bullet_controller: per-scenario tasks check position
// and state; hit pulses are matched against a queue of expected events.
module tb_bullet_controller;

   logic Clk;
   logic Reset_n;

   bullet_controller_if bif ();

   bullet_controller #(.MOVE_DIV(4), .COOLDOWN(8)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bif.slave)
   );

   typedef struct packed {
      logic wall;
      logic tank;
      int   idx;
   } ev_t;

   ev_t exp_q[$];
   ev_t ev;
   int  map_mem[300];
   int  checks = 0;
   int  errors = 0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   assign bif.tile_val = (bif.tile_idx >= 0 && bif.tile_idx < 300) ? map_mem[bif.tile_idx] : 0;

   // Pulse scoreboard: every wall/tank pulse must match the next queued event.
   always @(negedge Clk) begin
      if (Reset_n && (bif.wall_hit || bif.tank_hit)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pulse_unexpected: got wall_hit=%0b tank_hit=%0b wall_idx=%0d, required no pulse",
                     bif.wall_hit, bif.tank_hit, bif.wall_idx);
         end else begin
            ev = exp_q.pop_front();
            if (bif.wall_hit !== ev.wall || bif.tank_hit !== ev.tank ||
                (ev.wall && bif.wall_idx !== ev.idx)) begin
               errors++;
               $display("FAIL pulse_match: got wall=%0b tank=%0b idx=%0d, required wall=%0b tank=%0b idx=%0d",
                        bif.wall_hit, bif.tank_hit, bif.wall_idx, ev.wall, ev.tank, ev.idx);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      @(posedge Clk) #1 Reset_n = 1'b0;
      @(posedge Clk) #1 Reset_n = 1'b1;
   endtask

   task automatic tick_frame(int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk) #1 bif.frame_clk = 1'b1;
         repeat (4) @(posedge Clk);
         #1 bif.frame_clk = 1'b0;
         repeat (4) @(posedge Clk);
         #1;
      end
   endtask

   task automatic press_fire();
      @(posedge Clk) #1 bif.fire = 1'b1;
      repeat (4) @(posedge Clk);
      #1;
   endtask

   task automatic release_fire();
      bif.fire = 1'b0;
      repeat (4) @(posedge Clk);
      #1;
   endtask

   task automatic set_tank(int x, int y, logic [1:0] d);
      bif.TankX   = x;
      bif.TankY   = y;
      bif.TankDir = d;
   endtask

   task automatic test_reset();
      Reset_n       = 1'b0;
      bif.frame_clk = 1'b0;
      bif.fire      = 1'b0;
      bif.EnemyX    = 15;
      bif.EnemyY    = 12;
      set_tank(5, 5, 2'd1);
      repeat (3) @(posedge Clk);
      #1 Reset_n = 1'b1;
      checks++;
      if ({bif.BulX, bif.BulY, bif.active, bif.wall_hit, bif.tank_hit} !== {-32'sd1, -32'sd1, 3'b000}) begin
         errors++;
         $display("FAIL reset_bullet: got x=%0d y=%0d act=%0b wh=%0b th=%0b, required -1 -1 0 0 0",
                  bif.BulX, bif.BulY, bif.active, bif.wall_hit, bif.tank_hit);
      end
      checks++;
      if (bif.wall_idx !== 0 || bif.tile_idx !== 0) begin
         errors++;
         $display("FAIL reset_idx: got wall_idx=%0d tile_idx=%0d, required 0 0", bif.wall_idx, bif.tile_idx);
      end
   endtask

   task automatic test_launch_move();
      apply_reset();
      set_tank(5, 5, 2'd1);
      @(posedge Clk) #1 bif.fire = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      checks++;
      if (bif.BulX !== -1 || bif.active !== 1'b0) begin
         errors++;
         $display("FAIL launch_early: got x=%0d act=%0b at 3 cycles, required -1 0", bif.BulX, bif.active);
      end
      @(posedge Clk) #1;
      checks++;
      if ({bif.BulX, bif.BulY, bif.active} !== {32'sd6, 32'sd5, 1'b1}) begin
         errors++;
         $display("FAIL launch_pos: got (%0d,%0d) act=%0b, required (6,5) 1", bif.BulX, bif.BulY, bif.active);
      end
      release_fire();
      set_tank(0, 5, 2'd0);
      tick_frame(3);
      checks++;
      if ({bif.BulX, bif.BulY} !== {32'sd6, 32'sd5}) begin
         errors++;
         $display("FAIL move_3ticks: got (%0d,%0d), required (6,5)", bif.BulX, bif.BulY);
      end
      tick_frame(1);
      checks++;
      if ({bif.BulX, bif.BulY, bif.active} !== {32'sd7, 32'sd5, 1'b1}) begin
         errors++;
         $display("FAIL move_4ticks: got (%0d,%0d) act=%0b, required (7,5) 1", bif.BulX, bif.BulY, bif.active);
      end
   endtask

   task automatic test_bounds_hold_fire();
      apply_reset();
      set_tank(18, 3, 2'd1);
      press_fire();
      checks++;
      if ({bif.BulX, bif.BulY, bif.active} !== {32'sd19, 32'sd3, 1'b1}) begin
         errors++;
         $display("FAIL edge_launch: got (%0d,%0d) act=%0b, required (19,3) 1", bif.BulX, bif.BulY, bif.active);
      end
      tick_frame(4);
      checks++;
      if ({bif.BulX, bif.BulY, bif.active} !== {-32'sd1, -32'sd1, 1'b0}) begin
         errors++;
         $display("FAIL edge_kill: got (%0d,%0d) act=%0b, required (-1,-1) 0", bif.BulX, bif.BulY, bif.active);
      end
      tick_frame(9);
      checks++;
      if (bif.BulX !== -1 || bif.active !== 1'b0) begin
         errors++;
         $display("FAIL fire_level: got x=%0d act=%0b with fire held, required -1 0", bif.BulX, bif.active);
      end
      release_fire();
   endtask

   task automatic test_left_edge();
      apply_reset();
      set_tank(0, 7, 2'd3);
      press_fire();
      repeat (2) @(posedge Clk);
      #1;
      checks++;
      if ({bif.BulX, bif.BulY, bif.active} !== {-32'sd1, -32'sd1, 1'b0}) begin
         errors++;
         $display("FAIL left_edge: got (%0d,%0d) act=%0b, required (-1,-1) 0", bif.BulX, bif.BulY, bif.active);
      end
      release_fire();
   endtask

   task automatic test_cooldown();
      apply_reset();
      set_tank(18, 3, 2'd1);
      press_fire();
      release_fire();
      tick_frame(4);
      tick_frame(2);
      press_fire();
      repeat (2) @(posedge Clk);
      #1;
      checks++;
      if (bif.BulX !== -1 || bif.active !== 1'b0) begin
         errors++;
         $display("FAIL cooldown_block: got x=%0d act=%0b, required -1 0", bif.BulX, bif.active);
      end
      release_fire();
      tick_frame(6);
      press_fire();
      checks++;
      if ({bif.BulX, bif.BulY, bif.active} !== {32'sd19, 32'sd3, 1'b1}) begin
         errors++;
         $display("FAIL cooldown_release: got (%0d,%0d) act=%0b, required (19,3) 1", bif.BulX, bif.BulY, bif.active);
      end
      release_fire();
   endtask

   task automatic test_brick();
      apply_reset();
      map_mem[110] = 2;
      set_tank(7, 5, 2'd1);
      press_fire();
      release_fire();
      tick_frame(4);
      checks++;
      if ({bif.BulX, bif.BulY} !== {32'sd9, 32'sd5}) begin
         errors++;
         $display("FAIL brick_approach: got (%0d,%0d), required (9,5)", bif.BulX, bif.BulY);
      end
      exp_q.push_back('{wall: 1'b1, tank: 1'b0, idx: 110});
      tick_frame(4);
      checks++;
      if ({bif.BulX, bif.BulY, bif.active} !== {-32'sd1, -32'sd1, 1'b0}) begin
         errors++;
         $display("FAIL brick_kill: got (%0d,%0d) act=%0b, required (-1,-1) 0", bif.BulX, bif.BulY, bif.active);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL brick_pulse: got %0d pending events, required 0", exp_q.size());
      end
      map_mem[110] = 0;
   endtask

   task automatic test_tank_priority();
      apply_reset();
      bif.EnemyX  = 7;
      bif.EnemyY  = 2;
      map_mem[47] = 1;
      set_tank(7, 0, 2'd2);
      press_fire();
      release_fire();
      checks++;
      if ({bif.BulX, bif.BulY} !== {32'sd7, 32'sd1}) begin
         errors++;
         $display("FAIL prio_launch: got (%0d,%0d), required (7,1)", bif.BulX, bif.BulY);
      end
      exp_q.push_back('{wall: 1'b0, tank: 1'b1, idx: 0});
      tick_frame(4);
      checks++;
      if (exp_q.size() !== 0 || bif.active !== 1'b0) begin
         errors++;
         $display("FAIL prio_tank: got pending=%0d act=%0b, required 0 0", exp_q.size(), bif.active);
      end
      map_mem[47] = 0;
      bif.EnemyX  = 15;
      bif.EnemyY  = 12;
   endtask

   task automatic test_reset_mid_flight();
      apply_reset();
      set_tank(8, 9, 2'd1);
      press_fire();
      release_fire();
      checks++;
      if ({bif.BulX, bif.BulY} !== {32'sd9, 32'sd9}) begin
         errors++;
         $display("FAIL midflight_launch: got (%0d,%0d), required (9,9)", bif.BulX, bif.BulY);
      end
      apply_reset();
      checks++;
      if ({bif.BulX, bif.BulY, bif.active} !== {-32'sd1, -32'sd1, 1'b0}) begin
         errors++;
         $display("FAIL midflight_reset: got (%0d,%0d) act=%0b, required (-1,-1) 0", bif.BulX, bif.BulY, bif.active);
      end
      press_fire();
      checks++;
      if ({bif.BulX, bif.BulY, bif.active} !== {32'sd9, 32'sd9, 1'b1}) begin
         errors++;
         $display("FAIL midflight_refire: got (%0d,%0d) act=%0b, required (9,9) 1", bif.BulX, bif.BulY, bif.active);
      end
      release_fire();
   endtask

   initial begin
      for (int i = 0; i < 300; i++) map_mem[i] = 0;
      test_reset();
      test_launch_move();
      test_bounds_hold_fire();
      test_left_edge();
      test_cooldown();
      test_brick();
      test_tank_priority();
      test_reset_mid_flight();
      repeat (4) @(posedge Clk);
      #1;
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL final_queue: got %0d pending events, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
